// File: rtl/proc_pkg.sv
// Shared writeback types and register-file geometry.
// Used by the commit arbiter and its load skid FIFO.
package proc_pkg;

  localparam int REG_AW   = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              kill;
  } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Load-return skid FIFO with kill-by-address and
// per-entry live-match outputs for hazard queries.
module wb_skid_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [REG_AW-1:0]         i_push_reg,
  input  logic [DATA_W-1:0]         i_push_data,
  input  logic                      i_push_kill,
  input  logic                      i_pop,
  input  logic                      i_kill,
  input  logic [REG_AW-1:0]         i_kill_reg,
  input  logic [REG_AW-1:0]         i_q1,
  input  logic [REG_AW-1:0]         i_q2,
  output logic [REG_AW-1:0]         o_head_reg,
  output logic [DATA_W-1:0]         o_head_data,
  output logic                      o_head_kill,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [DEPTH-1:0]          o_hit1,
  output logic [DEPTH-1:0]          o_hit2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t      r_mem [DEPTH];
  logic [PW-1:0]  r_wr;
  logic [PW-1:0]  r_rd;
  logic [CW-1:0]  r_count;
  logic [DEPTH-1:0] w_occ;

  assign o_head_reg  = r_mem[r_rd].rd;
  assign o_head_data = r_mem[r_rd].data;
  assign o_head_kill = r_mem[r_rd].kill;
  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_count     = r_count;

  // Slot i is occupied when its distance from the head is below count.
  always_comb begin
    w_occ  = '0;
    o_hit1 = '0;
    o_hit2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ[i]  = ({1'b0, PW'(i) - r_rd} < r_count);
      o_hit1[i] = w_occ[i] & !r_mem[i].kill
                  & (r_mem[i].rd == i_q1);
      o_hit2[i] = w_occ[i] & !r_mem[i].kill
                  & (r_mem[i].rd == i_q2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (i_kill) begin
        for (int i = 0; i < DEPTH; i++)
          if (r_mem[i].rd == i_kill_reg)
            r_mem[i].kill <= 1'b1;
      end
      if (i_push) begin
        r_mem[r_wr] <= '{rd:   i_push_reg,
                         data: i_push_data,
                         kill: i_push_kill};
        r_wr <= r_wr + 1'b1;
      end
      if (i_pop)
        r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

endmodule

// File: rtl/regfile_write_commit.sv
// Register-file write port arbiter: ALU results win,
// loads queue behind them with WAW kills and busy flags.
module regfile_write_commit
  import proc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [REG_AW-1:0]      alu_reg,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [REG_AW-1:0]      ld_reg,
  input  logic [DATA_W-1:0]      ld_data,
  output logic                   write_enable,
  output logic [REG_AW-1:0]      write_reg,
  output logic [DATA_W-1:0]      write_data,
  input  logic [REG_AW-1:0]      q_reg1,
  input  logic [REG_AW-1:0]      q_reg2,
  output logic                   q_busy1,
  output logic                   q_busy2,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   drained
);

  logic              r_we;
  logic [REG_AW-1:0] r_reg;
  logic [DATA_W-1:0] r_data;

  logic              w_alu_ok;
  logic              w_ld_ok;
  logic              w_bypass;
  logic              w_push;
  logic              w_push_kill;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic [REG_AW-1:0] w_head_reg;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_kill;
  logic [DEPTH-1:0]  w_hit1;
  logic [DEPTH-1:0]  w_hit2;

  assign ld_ready    = !w_full;
  assign w_alu_ok    = alu_valid & !(DROP_R0 & (alu_reg == '0));
  assign w_ld_ok     = ld_valid & !w_full
                       & !(DROP_R0 & (ld_reg == '0));
  assign w_pop       = !w_alu_ok & !w_empty;
  assign w_bypass    = w_ld_ok & w_empty & !w_alu_ok;
  assign w_push      = w_ld_ok & !w_bypass;
  // A same-cycle load to the ALU's register is older: born dead.
  assign w_push_kill = w_alu_ok & (alu_reg == ld_reg);

  wb_skid_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_reg  (ld_reg),
    .i_push_data (ld_data),
    .i_push_kill (w_push_kill),
    .i_pop       (w_pop),
    .i_kill      (w_alu_ok),
    .i_kill_reg  (alu_reg),
    .i_q1        (q_reg1),
    .i_q2        (q_reg2),
    .o_head_reg  (w_head_reg),
    .o_head_data (w_head_data),
    .o_head_kill (w_head_kill),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_count     (fifo_count),
    .o_hit1      (w_hit1),
    .o_hit2      (w_hit2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_reg  <= '0;
      r_data <= '0;
    end else begin
      unique case (1'b1)
        w_alu_ok: begin
          r_we   <= 1'b1;
          r_reg  <= alu_reg;
          r_data <= alu_data;
        end
        w_pop: begin
          r_we <= !w_head_kill;
          if (!w_head_kill) begin
            r_reg  <= w_head_reg;
            r_data <= w_head_data;
          end
        end
        w_bypass: begin
          r_we   <= 1'b1;
          r_reg  <= ld_reg;
          r_data <= ld_data;
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

  assign write_enable = r_we;
  assign write_reg    = r_reg;
  assign write_data   = r_data;
  assign drained      = w_empty & !r_we;
  assign q_busy1      = (r_we & (r_reg == q_reg1)) | (|w_hit1);
  assign q_busy2      = (r_we & (r_reg == q_reg2)) | (|w_hit2);

endmodule

// File: tb/tb_regfile_write_commit.sv
// Scenario bench: expected writes queued at stimulus time,
// popped by a write-port monitor on the falling edge.
module tb_regfile_write_commit;
  import proc_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              alu_valid = 1'b0;
  logic [REG_AW-1:0] alu_reg = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_reg = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              write_enable;
  logic [REG_AW-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [REG_AW-1:0] q_reg1 = '0;
  logic [REG_AW-1:0] q_reg2 = '0;
  logic              q_busy1;
  logic              q_busy2;
  logic [2:0]        fifo_count;
  logic              drained;

  typedef struct {
    logic [REG_AW-1:0] r;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  regfile_write_commit #(.DEPTH(4), .DROP_R0(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_reg      (alu_reg),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_reg       (ld_reg),
    .ld_data      (ld_data),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .q_reg1       (q_reg1),
    .q_reg2       (q_reg2),
    .q_busy1      (q_busy1),
    .q_busy2      (q_busy2),
    .fifo_count   (fifo_count),
    .drained      (drained)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && write_enable) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got reg %0d data %h, required no write",
                 write_reg, write_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (write_reg !== mon_e.r || write_data !== mon_e.d) begin
          n_bad++;
          $display("FAIL sb_write: got reg %0d data %h, required reg %0d data %h",
                   write_reg, write_data, mon_e.r, mon_e.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] r, input logic [31:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (!(drained && exp_q.size() == 0) && k < 60) begin
      step();
      k++;
    end
    n_cmp++;
    if (!drained || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got drained %0b pending %0d, required 1 and 0",
               name, drained, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({write_enable, write_reg, write_data} !== '0) begin
      n_bad++;
      $display("FAIL rst_slot: got we %0b reg %0d data %h, required 0/0/0",
               write_enable, write_reg, write_data);
    end
    n_cmp++;
    if (fifo_count !== 3'd0 || ld_ready !== 1'b1 || drained !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_fifo: got count %0d ready %0b drained %0b, required 0/1/1",
               fifo_count, ld_ready, drained);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    q_reg1 = 4'd3;
    alu_valid = 1'b1;
    alu_reg = 4'd3;
    alu_data = 32'h11;
    push_exp(4'd3, 32'h11);
    step();
    alu_valid = 1'b0;
    n_cmp++;
    if (write_enable !== 1'b1 || write_reg !== 4'd3 || write_data !== 32'h11) begin
      n_bad++;
      $display("FAIL alu_slot: got we %0b reg %0d data %h, required 1/3/11",
               write_enable, write_reg, write_data);
    end
    n_cmp++;
    if (q_busy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL alu_busy_hi: got %0b, required 1", q_busy1);
    end
    step();
    n_cmp++;
    if (q_busy1 !== 1'b0 || write_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL alu_busy_lo: got busy %0b we %0b, required 0/0",
               q_busy1, write_enable);
    end
    wait_drain("alu");
  endtask

  task automatic test_bypass();
    q_reg2 = 4'd5;
    ld_valid = 1'b1;
    ld_reg = 4'd5;
    ld_data = 32'hAA;
    n_cmp++;
    if (ld_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL byp_ready: got %0b, required 1", ld_ready);
    end
    push_exp(4'd5, 32'hAA);
    step();
    ld_valid = 1'b0;
    n_cmp++;
    if (fifo_count !== 3'd0 || write_enable !== 1'b1 || q_busy2 !== 1'b1) begin
      n_bad++;
      $display("FAIL byp_slot: got count %0d we %0b busy %0b, required 0/1/1",
               fifo_count, write_enable, q_busy2);
    end
    wait_drain("byp");
  endtask

  task automatic test_back_to_back();
    int  idx = 0;
    int  k = 0;
    logic hs;
    for (int c = 0; c < 6; c++)
      push_exp(4'd10, 32'h100 + c);
    for (int i = 1; i <= 5; i++)
      push_exp(4'(i), 32'hA0 + i);
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1'b1;
      alu_reg = 4'd10;
      alu_data = 32'h100 + c;
      ld_valid = (idx < 5);
      ld_reg = 4'(idx + 1);
      ld_data = 32'hA0 + idx + 1;
      n_cmp++;
      if (ld_ready !== (c < 4)) begin
        n_bad++;
        $display("FAIL b2b_ready_c%0d: got %0b, required %0b",
                 c, ld_ready, (c < 4));
      end
      hs = ld_valid & ld_ready;
      step();
      if (hs) idx++;
    end
    alu_valid = 1'b0;
    n_cmp++;
    if (idx != 4 || fifo_count !== 3'd4) begin
      n_bad++;
      $display("FAIL b2b_full: got accepted %0d count %0d, required 4/4",
               idx, fifo_count);
    end
    while (idx < 5 && k < 20) begin
      ld_valid = 1'b1;
      ld_reg = 4'(idx + 1);
      ld_data = 32'hA0 + idx + 1;
      hs = ld_ready;
      step();
      if (hs) idx++;
      k++;
    end
    ld_valid = 1'b0;
    n_cmp++;
    if (idx != 5) begin
      n_bad++;
      $display("FAIL b2b_last_load: got accepted %0d, required 5", idx);
    end
    wait_drain("b2b");
  endtask

  task automatic test_waw_kill();
    q_reg1 = 4'd7;
    alu_valid = 1'b1;
    alu_reg = 4'd12;
    alu_data = 32'h33;
    ld_valid = 1'b1;
    ld_reg = 4'd7;
    ld_data = 32'h1;
    push_exp(4'd12, 32'h33);
    push_exp(4'd7, 32'h2);
    step();
    ld_valid = 1'b0;
    n_cmp++;
    if (q_busy1 !== 1'b1 || fifo_count !== 3'd1) begin
      n_bad++;
      $display("FAIL waw_queued: got busy %0b count %0d, required 1/1",
               q_busy1, fifo_count);
    end
    alu_reg = 4'd7;
    alu_data = 32'h2;
    step();
    alu_valid = 1'b0;
    n_cmp++;
    if (q_busy1 !== 1'b1 || fifo_count !== 3'd1) begin
      n_bad++;
      $display("FAIL waw_alu: got busy %0b count %0d, required 1/1",
               q_busy1, fifo_count);
    end
    step();
    n_cmp++;
    if (write_enable !== 1'b0 || fifo_count !== 3'd0 || q_busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL waw_killpop: got we %0b count %0d busy %0b, required 0/0/0",
               write_enable, fifo_count, q_busy1);
    end
    wait_drain("waw");
  endtask

  task automatic test_same_cycle();
    q_reg2 = 4'd9;
    alu_valid = 1'b1;
    alu_reg = 4'd9;
    alu_data = 32'h99;
    ld_valid = 1'b1;
    ld_reg = 4'd9;
    ld_data = 32'h55;
    n_cmp++;
    if (ld_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL same_ready: got %0b, required 1", ld_ready);
    end
    push_exp(4'd9, 32'h99);
    step();
    alu_valid = 1'b0;
    ld_valid = 1'b0;
    n_cmp++;
    if (fifo_count !== 3'd1 || q_busy2 !== 1'b1) begin
      n_bad++;
      $display("FAIL same_enq: got count %0d busy %0b, required 1/1",
               fifo_count, q_busy2);
    end
    step();
    n_cmp++;
    if (write_enable !== 1'b0 || fifo_count !== 3'd0 || q_busy2 !== 1'b0) begin
      n_bad++;
      $display("FAIL same_pop: got we %0b count %0d busy %0b, required 0/0/0",
               write_enable, fifo_count, q_busy2);
    end
    wait_drain("same");
  endtask

  task automatic test_reset_mid();
    int bad_we = 0;
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1;
      alu_reg = 4'd13;
      alu_data = 32'h200 + c;
      ld_valid = 1'b1;
      ld_reg = 4'(c + 1);
      ld_data = 32'hB0 + c;
      if (c < 2) push_exp(4'd13, 32'h200 + c);
      step();
    end
    alu_valid = 1'b0;
    ld_valid = 1'b0;
    n_cmp++;
    if (fifo_count !== 3'd3) begin
      n_bad++;
      $display("FAIL rmid_queued: got count %0d, required 3", fifo_count);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({write_enable, write_reg, write_data} !== '0 || fifo_count !== 3'd0
        || ld_ready !== 1'b1 || drained !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_async: got we %0b reg %0d data %h count %0d rdy %0b drn %0b",
               write_enable, write_reg, write_data, fifo_count, ld_ready, drained);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (write_enable !== 1'b0 || fifo_count !== 3'd0) bad_we++;
    end
    n_cmp++;
    if (bad_we != 0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rmid_after: got %0d active cycles %0d pending, required 0/0",
               bad_we, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_bypass();
    test_back_to_back();
    test_waw_kill();
    test_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
